// File: rtl/wb_block_copy.sv
// Wishbone-style block copier: reads word_count words from src_addr and writes them to dst_addr
// one word at a time through a simple start/ack/err bus-master handshake.
module wb_block_copy #(
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          go,
  input  logic [aw-1:0] src_addr,
  input  logic [aw-1:0] dst_addr,
  input  logic [15:0]   word_count,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_done,
  output logic          m_start,
  output logic [aw-1:0] m_address,
  output logic [3:0]    m_selection,
  output logic          m_write,
  output logic [dw-1:0] m_data_wr,
  input  logic [dw-1:0] m_data_rd,
  input  logic          m_ack,
  input  logic          m_err
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StFinish} state_e;

  state_e        state_q;
  logic [aw-1:0] src_ptr_q;
  logic [aw-1:0] dst_ptr_q;
  logic [15:0]   count_q;
  logic [15:0]   index_q;
  logic [TW-1:0] timer_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      count_q     <= '0;
      index_q     <= '0;
      timer_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      words_done  <= '0;
      m_start     <= 1'b0;
      m_address   <= '0;
      m_selection <= '0;
      m_write     <= 1'b0;
      m_data_wr   <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            src_ptr_q  <= src_addr;
            dst_ptr_q  <= dst_addr;
            count_q    <= word_count;
            index_q    <= '0;
            words_done <= '0;
            error      <= 1'b0;
            busy       <= 1'b1;
            if (word_count == 16'd0) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else begin
              state_q     <= StRdReq;
              m_start     <= 1'b1;
              m_write     <= 1'b0;
              m_address   <= src_addr;
              m_selection <= 4'hF;
            end
          end
        end
        StRdReq: begin
          state_q <= StRdWait;
          timer_q <= '0;
        end
        StRdWait: begin
          // m_err wins over a simultaneous m_ack
          if (m_err || (!m_ack && timer_q == TimerMax)) begin
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= StFinish;
          end else if (m_ack) begin
            m_data_wr <= m_data_rd;
            m_start   <= 1'b1;
            m_write   <= 1'b1;
            m_address <= dst_ptr_q;
            state_q   <= StWrReq;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StWrReq: begin
          state_q <= StWrWait;
          timer_q <= '0;
        end
        StWrWait: begin
          if (m_err || (!m_ack && timer_q == TimerMax)) begin
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= StFinish;
          end else if (m_ack) begin
            index_q    <= index_q + 16'd1;
            words_done <= words_done + 16'd1;
            src_ptr_q  <= src_ptr_q + aw'(4);
            dst_ptr_q  <= dst_ptr_q + aw'(4);
            if (index_q + 16'd1 == count_q) begin
              done    <= 1'b1;
              state_q <= StFinish;
            end else begin
              m_start   <= 1'b1;
              m_write   <= 1'b0;
              m_address <= src_ptr_q + aw'(4);
              state_q   <= StRdReq;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StFinish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_block_copy.sv
// Scoreboard bench for wb_block_copy: a bus-slave model answers transfers, expected transfers and
// completion records are queued by the stimulus and checked by an independent monitor.
module tb_wb_block_copy;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, error, m_start, m_write;
  logic [15:0] words_done;
  logic [31:0] m_address, m_data_wr;
  logic [3:0]  m_selection;
  logic [31:0] m_data_rd = '0;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;

  wb_block_copy #(.dw(32), .aw(32), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .go(go), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error), .words_done(words_done),
    .m_start(m_start), .m_address(m_address), .m_selection(m_selection), .m_write(m_write),
    .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_ack(m_ack), .m_err(m_err)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;
  typedef struct packed {logic [15:0] words; logic err;} fin_t;

  txn_t exp_q[$];
  fin_t fin_q[$];
  int checks = 0;
  int fails = 0;

  // Slave behaviour: fault_kind 0 = normal, 1 = m_err on txn fault_at, 2 = silence on fault_at
  logic [31:0] salt = '0;
  int fault_kind = 0;
  int fault_at = 0;
  int fixed_delay = -1;
  int txn_idx = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor
  txn_t mon_e;
  fin_t mon_f;
  initial forever begin
    @(negedge wb_clk);
    if (m_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected m_start: addr %0h write %0b, expected none", m_address, m_write);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer write", 64'(m_write), 64'(mon_e.wr));
        check("xfer addr", 64'(m_address), 64'(mon_e.addr));
        if (mon_e.wr) check("xfer data", 64'(m_data_wr), 64'(mon_e.data));
        check("byte enables", 64'(m_selection), 64'(4'hF));
      end
    end
    if (done === 1'b1) begin
      if (fin_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected done: words_done %0d, expected no done", words_done);
      end else begin
        mon_f = fin_q.pop_front();
        check("words_done at done", 64'(words_done), 64'(mon_f.words));
        check("error at done", 64'(error), 64'(mon_f.err));
      end
    end
  end

  // Bus slave
  logic [31:0] sl_addr;
  int sl_idx, sl_dly;
  initial forever begin
    @(negedge wb_clk);
    if (m_start === 1'b1) begin
      sl_addr = m_address;
      sl_idx  = txn_idx;
      txn_idx++;
      if (!(fault_kind == 2 && sl_idx == fault_at)) begin
        sl_dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        repeat (sl_dly + 1) @(posedge wb_clk);
        #1;
        if (fault_kind == 1 && sl_idx == fault_at) begin
          m_err = 1'b1;
          m_ack = 1'($urandom_range(0, 1));
        end else begin
          m_ack     = 1'b1;
          m_data_rd = mem_word(sl_addr, salt);
        end
        @(posedge wb_clk);
        #1;
        m_ack = 1'b0;
        m_err = 1'b0;
      end
    end
  end

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int fk, input int fa, input int dly, input int exp_lat,
                          input bit spur);
    int   k_last, lat, bound;
    fin_t f;
    salt = $urandom;
    fault_kind = fk;
    fault_at = fa;
    fixed_delay = dly;
    txn_idx = 0;
    k_last = (fk == 0) ? 2 * int'(n) - 1 : fa;
    for (int t = 0; t <= k_last; t++) begin
      txn_t e;
      e.wr   = 1'(t % 2);
      e.addr = e.wr ? d + 32'(4 * (t / 2)) : s + 32'(4 * (t / 2));
      e.data = mem_word(s + 32'(4 * (t / 2)), salt);
      exp_q.push_back(e);
    end
    f.words = (fk == 0) ? n : 16'(fa / 2);
    f.err   = (fk != 0);
    fin_q.push_back(f);
    @(negedge wb_clk);
    src_addr = s;
    dst_addr = d;
    word_count = n;
    go = 1'b1;
    @(posedge wb_clk);
    #1;
    go = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    lat = 0;
    bound = 24 * int'(n) + 20;
    fork
      begin
        while (done !== 1'b1 && lat < bound) begin
          @(posedge wb_clk);
          #1;
          lat++;
        end
      end
      begin
        if (spur) begin
          repeat (3) @(negedge wb_clk);
          src_addr = $urandom;
          dst_addr = $urandom;
          word_count = 16'd7;
          go = 1'b1;
          @(negedge wb_clk);
          go = 1'b0;
        end
      end
    join
    if (done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL done timeout: no done after %0d cycles, expected done", lat);
      exp_q.delete();
      fin_q.delete();
    end else if (exp_lat >= 0) begin
      check("done latency", 64'(lat), 64'(exp_lat));
    end
    @(posedge wb_clk);
    #1;
    check("busy after finish", 64'(busy), 64'(0));
    check("done single cycle", 64'(done), 64'(0));
    check("error sticky", 64'(error), 64'(f.err));
    check("pending xfers", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " error"}, 64'(error), 64'(0));
    check({tag, " words_done"}, 64'(words_done), 64'(0));
    check({tag, " m_start"}, 64'(m_start), 64'(0));
    check({tag, " m_write"}, 64'(m_write), 64'(0));
    check({tag, " m_address"}, 64'(m_address), 64'(0));
    check({tag, " m_data_wr"}, 64'(m_data_wr), 64'(0));
    check({tag, " m_selection"}, 64'(m_selection), 64'(0));
  endtask

  initial begin
    int lat;
    logic [31:0] s;
    logic [15:0] n;
    int fk;
    repeat (3) @(posedge wb_clk);
    #1;
    check_all_zero("reset");
    @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    run_copy(32'h100, 32'h200, 16'd3, 0, 0, 0, 12, 1'b0);
    run_copy(32'h300, 32'h400, 16'd0, 0, 0, 0, -1, 1'b0);
    run_copy(32'h100, 32'h200, 16'd4, 1, 2, -1, -1, 1'b0);
    run_copy(32'h500, 32'h600, 16'd3, 2, 1, -1, -1, 1'b0);
    run_copy(32'h700, 32'h800, 16'd3, 0, 0, -1, -1, 1'b1);
    run_copy(32'hFFFF_FFFC, 32'h900, 16'd2, 0, 0, -1, -1, 1'b0);

    // Reset in the middle of a write wait, with a go in the same cycle
    salt = $urandom;
    fault_kind = 2;
    fault_at = 1;
    fixed_delay = 0;
    txn_idx = 0;
    exp_q.push_back('{wr: 1'b0, addr: 32'h1000, data: '0});
    exp_q.push_back('{wr: 1'b1, addr: 32'h2000, data: mem_word(32'h1000, salt)});
    @(negedge wb_clk);
    src_addr = 32'h1000;
    dst_addr = 32'h2000;
    word_count = 16'd5;
    go = 1'b1;
    @(negedge wb_clk);
    go = 1'b0;
    lat = 0;
    while (!(m_start === 1'b1 && m_write === 1'b1) && lat < 50) begin
      @(negedge wb_clk);
      lat++;
    end
    check("write request seen", 64'(m_start & m_write), 64'(1));
    @(negedge wb_clk);
    wb_rst = 1'b1;
    go = 1'b1;
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    go = 1'b0;
    check_all_zero("mid-copy reset");
    repeat (3) @(posedge wb_clk);
    #1;
    check("go during reset ignored", 64'(busy), 64'(0));
    check("no xfer after reset", 64'(exp_q.size()), 64'(0));
    fault_kind = 0;
    run_copy(32'h3000, 32'h4000, 16'd2, 0, 0, -1, -1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      s = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0;
      n = 16'($urandom_range(1, 6));
      fk = int'($urandom_range(0, 4));
      if (fk > 2) fk = 0;
      run_copy(s, $urandom & 32'hFFFF_FFFC, n, fk, int'($urandom_range(0, 2 * int'(n) - 1)),
               -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_block_copy.md
WB_BLOCK_COPY -- requirements
Module: wb_block_copy

Interface
REQ-001 Parameter dw, default 32, data word width.
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles in a wait state before abort; must be at least 1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 wb_clk  in  1  clock; all state updates on its rising edge.
REQ-006 wb_rst  in  1  synchronous active-high reset.
REQ-007 go  in  1  single-cycle request to start a copy.
REQ-008 src_addr  in  aw  byte address of the first source word.
REQ-009 dst_addr  in  aw  byte address of the first destination word.
REQ-010 word_count  in  16  number of words to copy.
REQ-011 busy  out  1  high while a copy is in progress.
REQ-012 done  out  1  one-cycle pulse when a copy ends, on success or on error.
REQ-013 error  out  1  sticky abort flag; cleared by the next accepted go.
REQ-014 words_done  out  16  count of completed word writes.
REQ-015 m_start  out  1  one-cycle request to the downstream bus master.
REQ-016 m_address  out  aw  transfer byte address.
REQ-017 m_selection  out  4  byte enables; always 4'hF while m_start is high.
REQ-018 m_write  out  1  1 = write, 0 = read.
REQ-019 m_data_wr  out  dw  write data.
REQ-020 m_data_rd  in  dw  read data; valid in the cycle m_ack is high.
REQ-021 m_ack  in  1  transfer completed normally.
REQ-022 m_err  in  1  transfer terminated by a bus error or retry.

Function
REQ-023 All outputs are registered.
REQ-024 State machine states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE, go=1, word_count=0 -> FINISH.
- IDLE, go=1, word_count>0 -> RD_REQ.
REQ-025 On an accepted go, the block latches src_addr, dst_addr and word_count, clears error, clears words_done, and sets busy.
REQ-026 go is ignored in every state other than IDLE.
REQ-027 RD_REQ lasts exactly one cycle and drives:
- m_start=1, m_write=0;
- m_address = src_base + 4*index, truncated to aw bits (wrap-around permitted).
REQ-028 RD_WAIT:
- m_ack=1 -> capture m_data_rd into the data holding register, then go to WR_REQ;
- m_err=1 -> abort;
- otherwise stay.
REQ-029 WR_REQ lasts exactly one cycle and drives:
- m_start=1, m_write=1;
- m_address = dst_base + 4*index;
- m_data_wr = the held data.
REQ-030 WR_WAIT, m_ack=1: increment index and words_done, then:
- go to FINISH if index+1 equals the latched count;
- otherwise go to RD_REQ.
REQ-031 WR_WAIT, m_err=1 -> abort.
REQ-032 If m_err and m_ack are high in the same cycle, m_err takes priority.
REQ-033 The wait timer clears on entering RD_WAIT or WR_WAIT and increments each cycle spent waiting.
REQ-034 Reaching TIMEOUT with no m_ack or m_err -> abort.
REQ-035 Abort means: set error=1, go to FINISH, leave words_done unchanged.
REQ-036 FINISH lasts one cycle: done=1, busy=0 on exit, then IDLE.
REQ-037 m_start is 0 in every state except RD_REQ and WR_REQ.
REQ-038 m_address, m_write and m_data_wr hold their values through the following wait state.
REQ-039 m_ack or m_err arriving while not in a wait state is ignored.
REQ-040 Minimum throughput is 4 cycles per word, when m_ack arrives in the first wait cycle.

Reset
REQ-041 wb_rst=1 forces state to IDLE in the next cycle, including in the middle of a copy.
REQ-042 Reset values: busy=0, done=0, error=0, words_done=0, m_start=0, m_write=0, m_address=0, m_data_wr=0, m_selection=0, index=0, wait timer=0.
REQ-043 A go asserted in the same cycle as wb_rst is ignored.

Verification
REQ-044 go with src=0x100, dst=0x200, count=3, ack one cycle after each m_start -> reads at 0x100/0x104/0x108, writes at 0x200/0x204/0x208 with the read data, done pulses 12 cycles after go, words_done=3, error=0.
REQ-045 go with count=0 -> no m_start, done pulses the cycle after FINISH is entered, busy deasserted, error=0.
REQ-046 count=4, m_err on the second read -> error=1, done pulses, words_done=1, no further m_start.
REQ-047 TIMEOUT=8, no ack after the first write request -> after 8 wait cycles: error=1, done=1, words_done=0.
REQ-048 go pulsed while busy -> ignored, latched addresses unchanged; wb_rst in WR_WAIT -> all outputs 0 next cycle, then a fresh go runs normally.
REQ-049 src=0xFFFFFFFC, count=2 -> second read address wraps to 0x00000000.
